// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target memory.
// States, ACK level and byte width used by the bus FSM.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    MEM_ADDR,
    MEM_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } slv_state_t;

  localparam logic I2C_ACK    = 1'b0;
  localparam int   I2C_BYTE_W = 8;

endpackage

// File: rtl/i2c_bus_cond.sv
// scl/sda synchronizers, scl edge detect and START/STOP detect.
// Index 1 is the synchronized value, index 2 the history flop.
module i2c_bus_cond (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2]
                   & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2]
                   & ~sda_q[2] & sda_q[1];
  assign sda_s     = sda_q[1];

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C target with a byte-addressed register file.
// Define I2C_SLV_AUTOINC_EN to auto-increment the pointer.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         DEPTH    = 16,
  localparam int        PW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          nack_seen
);

  logic scl_rise, scl_fall;
  logic start_det, stop_det, sda_s;

  i2c_bus_cond u_cond (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  slv_state_t state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [I2C_BYTE_W-1:0] sh_q, sh_n;
  logic [PW-1:0] ptr_q, ptr_n, ptr_inc;
  logic rw_q, rw_n;
  logic oe_q, oe_n;
  logic busy_q, busy_n;
  logic we, nack_n;
  logic [I2C_BYTE_W-1:0] byte_in;
  logic [I2C_BYTE_W-1:0] mem [DEPTH];
  logic shifting, addr_hit;

  assign byte_in  = {sh_q[6:0], sda_s};
  assign addr_hit = byte_in[7:1] == SLV_ADDR;
  assign shifting = state_q == ADDR
                 || state_q == MEM_ADDR
                 || state_q == WR_DATA;

`ifdef I2C_SLV_AUTOINC_EN
  assign ptr_inc = ptr_q + PW'(1);
`else
  assign ptr_inc = ptr_q;
`endif

  assign sda = oe_q ? 1'b0 : 1'bz;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sh_n    = sh_q;
    ptr_n   = ptr_q;
    rw_n    = rw_q;
    oe_n    = oe_q;
    busy_n  = busy_q;
    we      = 1'b0;
    nack_n  = 1'b0;
    if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (scl_rise) begin
      if (shifting && cnt_q != 4'd8) begin
        sh_n  = byte_in;
        cnt_n = cnt_q + 4'd1;
      end
      if (shifting && cnt_q == 4'd7) begin
        unique case (1'b1)
          state_q == ADDR && addr_hit: begin
            rw_n   = byte_in[0];
            busy_n = 1'b1;
          end
          state_q == ADDR && !addr_hit: begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
          state_q == MEM_ADDR:
            ptr_n = byte_in[PW-1:0];
          default:
            we = 1'b1;
        endcase
      end
      if (state_q == RD_ACK) begin
        if (sda_s == I2C_ACK) begin
          ptr_n   = ptr_inc;
          sh_n    = mem[ptr_inc];
          cnt_n   = '0;
          state_n = RD_DATA;
        end else begin
          nack_n  = 1'b1;
          state_n = IDLE;
        end
      end
    end else if (scl_fall) begin
      unique case (state_q)
        ADDR, MEM_ADDR, WR_DATA: begin
          if (cnt_q == 4'd8) begin
            oe_n  = 1'b1;
            cnt_n = '0;
            unique case (1'b1)
              state_q == ADDR:     state_n = ADDR_ACK;
              state_q == MEM_ADDR: state_n = MEM_ACK;
              default:             state_n = WR_ACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (rw_q) begin
            sh_n    = {mem[ptr_q][6:0], 1'b0};
            oe_n    = ~mem[ptr_q][7];
            cnt_n   = 4'd1;
            state_n = RD_DATA;
          end else begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = MEM_ADDR;
          end
        end
        MEM_ACK: begin
          oe_n    = 1'b0;
          cnt_n   = '0;
          state_n = WR_DATA;
        end
        WR_ACK: begin
          oe_n    = 1'b0;
          cnt_n   = '0;
          ptr_n   = ptr_inc;
          state_n = WR_DATA;
        end
        RD_DATA: begin
          if (cnt_q == 4'd8) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = RD_ACK;
          end else begin
            oe_n  = ~sh_q[7];
            sh_n  = {sh_q[6:0], 1'b0};
            cnt_n = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      nack_seen <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      sh_q      <= sh_n;
      ptr_q     <= ptr_n;
      rw_q      <= rw_n;
      oe_q      <= oe_n;
      busy_q    <= busy_n;
      wr_valid  <= we;
      nack_seen <= nack_n;
      if (we) begin
        wr_addr <= ptr_q;
        wr_data <= byte_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[ptr_q] <= byte_in;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: bit-banged master, vector
// table of write/readback pairs plus multi-cycle corner sequences.
module tb_i2c_slave_mem;

`ifdef I2C_SLV_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic m_oe = 1'b0;
  wire  sda;
  logic wr_valid, busy, nack_seen;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_mem dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl_m),
    .sda      (sda),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .nack_seen(nack_seen)
  );

  int errs = 0;
  int nchk = 0;
  logic [11:0] wlog [$];
  int nack_cnt = 0;
  int busy_cnt = 0;
  int foreign_cnt = 0;

  always @(negedge clk) begin
    if (wr_valid) wlog.push_back({wr_addr, wr_data});
    if (nack_seen) nack_cnt++;
    if (busy) busy_cnt++;
    if (!m_oe && sda === 1'b0) foreign_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hq();
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; hq();
    scl_m = 1'b1; hq(); hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic recv_bit(output logic b);
    m_oe = 1'b0; hq();
    scl_m = 1'b1; hq();
    b = sda; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic start();
    m_oe = 1'b0; hq();
    scl_m = 1'b1; hq();
    m_oe = 1'b1; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic stop();
    m_oe = 1'b1; hq();
    scl_m = 1'b1; hq();
    m_oe = 1'b0; hq(); hq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) recv_bit(b[i]);
    send_bit(nack);
  endtask

  task automatic rd1(input logic [7:0] a, output logic [7:0] d);
    logic k;
    start(); wr_byte(8'hA0, k); wr_byte(a, k);
    start(); wr_byte(8'hA1, k);
    rd_byte(1'b1, d); stop();
  endtask

  typedef struct {
    logic [7:0] maddr;
    logic [7:0] wdata;
    logic [3:0] eaddr;
    logic [7:0] edata;
  } vec_t;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [4];
    logic k;
    logic [7:0] d;
    logic [7:0] d2;
    int b, n0, f0, bz0;

    tbl[0] = '{8'h01, 8'h3C, 4'd1,  8'h3C};
    tbl[1] = '{8'h8E, 8'hC3, 4'd14, 8'hC3};
    tbl[2] = '{8'h00, 8'hFF, 4'd0,  8'hFF};
    tbl[3] = '{8'h4F, 8'h01, 4'd15, 8'h01};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst wr_valid", wr_valid, 0);
    chk("rst nack", nack_seen, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst sda", sda, 1);
    hq();

    // three-byte write from pointer 2
    b = wlog.size();
    start();
    wr_byte(8'hA0, k); chk("w3 ack addr", k, 0);
    wr_byte(8'h02, k); chk("w3 ack mem", k, 0);
    wr_byte(8'h11, k); chk("w3 ack d0", k, 0);
    wr_byte(8'h22, k); chk("w3 ack d1", k, 0);
    wr_byte(8'h33, k); chk("w3 ack d2", k, 0);
    chk("w3 busy", busy, 1);
    stop();
    chk("w3 count", wlog.size() - b, 3);
    chk("w3 e0", wlog[b], {4'd2, 8'h11});
    chk("w3 e1", wlog[b+1], AI ? {4'd3, 8'h22} : {4'd2, 8'h22});
    chk("w3 e2", wlog[b+2], AI ? {4'd4, 8'h33} : {4'd2, 8'h33});
    chk("w3 busy end", busy, 0);

    // pointer set, repeated START, two-byte read
    n0 = nack_cnt;
    start(); wr_byte(8'hA0, k); wr_byte(8'h03, k);
    start(); wr_byte(8'hA1, k);
    chk("rd ack addr", k, 0);
    rd_byte(1'b0, d);
    rd_byte(1'b1, d2);
    chk("rd b0", d, AI ? 8'h22 : 8'h00);
    chk("rd b1", d2, AI ? 8'h33 : 8'h00);
    chk("rd busy pre-stop", busy, 1);
    stop();
    chk("rd nack count", nack_cnt - n0, 1);
    chk("rd busy end", busy, 0);

    // address mismatch
    b = wlog.size(); f0 = foreign_cnt; bz0 = busy_cnt;
    start();
    wr_byte(8'hA2, k); chk("mm ack", k, 1);
    wr_byte(8'h55, k); chk("mm ack2", k, 1);
    stop();
    chk("mm sda driven", foreign_cnt - f0, 0);
    chk("mm busy", busy_cnt - bz0, 0);
    chk("mm writes", wlog.size() - b, 0);

    // pointer wrap: upper bits of 0x1F dropped
    b = wlog.size();
    start(); wr_byte(8'hA0, k); wr_byte(8'h1F, k);
    wr_byte(8'hAA, k); wr_byte(8'hBB, k); stop();
    chk("wrap count", wlog.size() - b, 2);
    chk("wrap e0", wlog[b], {4'd15, 8'hAA});
    chk("wrap e1", wlog[b+1], AI ? {4'd0, 8'hBB} : {4'd15, 8'hBB});

    // STOP mid MEM_ADDR keeps the pointer
    start(); wr_byte(8'hA0, k); wr_byte(8'h07, k);
    wr_byte(8'h5C, k); stop();
    start(); wr_byte(8'hA0, k); wr_byte(8'h07, k); stop();
    start(); wr_byte(8'hA0, k);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("mid busy", busy, 1);
    stop();
    chk("mid busy end", busy, 0);
    start(); wr_byte(8'hA1, k); rd_byte(1'b1, d); stop();
    chk("mid ptr", d, 8'h5C);

    // reset during WR_DATA after five bits
    b = wlog.size();
    start(); wr_byte(8'hA0, k); wr_byte(8'h05, k);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("rst-mid busy pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-mid busy", busy, 0);
    chk("rst-mid sda", sda, 1);
    hq(); scl_m = 1'b1; hq(); hq();
    chk("rst-mid writes", wlog.size() - b, 0);
    for (int r = 0; r < 16; r++) begin
      rd1(8'(r), d);
      chk($sformatf("rst-mid reg%0d", r), d, 8'h00);
    end

    // vector table: single write then readback
    for (int i = 0; i < 4; i++) begin
      b = wlog.size();
      start(); wr_byte(8'hA0, k); wr_byte(tbl[i].maddr, k);
      wr_byte(tbl[i].wdata, k); stop();
      chk($sformatf("vec%0d count", i), wlog.size() - b, 1);
      chk($sformatf("vec%0d wr", i), wlog[b],
          {tbl[i].eaddr, tbl[i].edata});
      rd1(tbl[i].maddr, d);
      chk($sformatf("vec%0d rd", i), d, tbl[i].edata);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
